// File: rtl/vga_pkg.sv
// Shared VGA/game-layer constants and types for the 1024x768 display pipeline.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_pkg;

    localparam int HOR_PIXELS         = 1024;
    localparam int VER_PIXELS         = 768;
    localparam int DUCK_WIDTH         = 96;
    localparam int DUCK_HEIGHT        = 60;
    localparam int KILLED_DUCK_HEIGHT = 96;

    // Ground line; the bottom of any duck sprite never goes below it.
    localparam int GROUND_Y   = 600;
    // Largest left-edge x that keeps the duck fully on screen.
    localparam int DUCK_X_MAX = HOR_PIXELS - DUCK_WIDTH;

    typedef enum logic [2:0] {
        DUCK_IDLE   = 3'd0,
        DUCK_FLY    = 3'd1,
        DUCK_HIT    = 3'd2,
        DUCK_FALL   = 3'd3,
        DUCK_ESCAPE = 3'd4
    } duck_state_t;

endpackage

// File: rtl/duck_flight_ctrl_motion_step.sv
// Combinational clamp-and-flip position step for one frame of duck flight.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the output is valid whenever the inputs are.
// Ports: x_in/y_in and hdir_in (1=right)/vdir_in (1=down) in; per-axis speed and
//        upper limit in; next x/y and next direction bits out.
module duck_motion_step (
    input  logic [10:0] x_in,
    input  logic [10:0] y_in,
    input  logic        hdir_in,
    input  logic        vdir_in,
    input  logic [10:0] x_speed,
    input  logic [10:0] y_speed,
    input  logic [10:0] x_max,
    input  logic [10:0] y_max,
    output logic [10:0] x_out,
    output logic [10:0] y_out,
    output logic        hdir_out,
    output logic        vdir_out
);
    // Sums are carried in 12 bits so the limit compare sees the true value.
    logic [11:0] x_sum;
    logic [11:0] y_sum;

    always_comb begin
        x_sum    = {1'b0, x_in} + {1'b0, x_speed};
        y_sum    = {1'b0, y_in} + {1'b0, y_speed};
        x_out    = x_in;
        y_out    = y_in;
        hdir_out = hdir_in;
        vdir_out = vdir_in;

        if (hdir_in) begin
            if (x_sum >= {1'b0, x_max}) begin
                x_out    = x_max;
                hdir_out = 1'b0;
            end else begin
                x_out = x_sum[10:0];
            end
        end else begin
            if (x_in <= x_speed) begin
                x_out    = '0;
                hdir_out = 1'b1;
            end else begin
                x_out = x_in - x_speed;
            end
        end

        if (vdir_in) begin
            if (y_sum >= {1'b0, y_max}) begin
                y_out    = y_max;
                vdir_out = 1'b0;
            end else begin
                y_out = y_sum[10:0];
            end
        end else begin
            if (y_in <= y_speed) begin
                y_out    = '0;
                vdir_out = 1'b1;
            end else begin
                y_out = y_in - y_speed;
            end
        end
    end

endmodule

// File: rtl/duck_flight_ctrl.sv
// Per-duck motion sequencer: launch, per-frame bounce flight, hit-hold-fall, escape.
// Latency: state/position registered, visible one cycle after the causing input.
// Backpressure: none; start/hit are single-cycle pulses ignored outside their states.
// Ports: clk/rst; frame_tick, start(+start_xpos/start_dir), hit in;
//        duck_xpos/ypos/state/visible to sprite stage; duck_killed/duck_escaped pulses out.
module duck_flight_ctrl
    import vga_pkg::*;
#(
    parameter int X_SPEED         = 4,
    parameter int Y_SPEED         = 3,
    parameter int FALL_SPEED      = 6,
    parameter int HIT_HOLD_FRAMES = 30,
    parameter int FLIGHT_FRAMES   = 600,
    parameter int GND_Y           = GROUND_Y
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [10:0] start_xpos,
    input  logic        start_dir,
    input  logic        hit,
    output logic [10:0] duck_xpos,
    output logic [10:0] duck_ypos,
    output duck_state_t duck_state,
    output logic        duck_visible,
    output logic        duck_killed,
    output logic        duck_escaped
);
    localparam int CNT_W = $clog2(((FLIGHT_FRAMES > HIT_HOLD_FRAMES) ?
                                   FLIGHT_FRAMES : HIT_HOLD_FRAMES) + 1);

    localparam logic [10:0] XS     = 11'(X_SPEED);
    localparam logic [10:0] YS     = 11'(Y_SPEED);
    localparam logic [10:0] X_MAX  = 11'(DUCK_X_MAX);
    localparam logic [10:0] Y_FLY  = 11'(GND_Y - DUCK_HEIGHT);
    localparam logic [10:0] Y_DEAD = 11'(GND_Y - KILLED_DUCK_HEIGHT);
    localparam logic [11:0] FS     = 12'(FALL_SPEED);
    localparam logic [CNT_W-1:0] FLY_LAST  = CNT_W'(FLIGHT_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HIT_HOLD_FRAMES - 1);

    duck_state_t      state_q, state_d;
    logic [10:0]      xpos_q, xpos_d;
    logic [10:0]      ypos_q, ypos_d;
    logic             hdir_q, hdir_d;     // 1 = moving right
    logic             vdir_q, vdir_d;     // 1 = moving down, 0 = up
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             killed_q, killed_d;
    logic             escaped_q, escaped_d;
    logic             visible_q, visible_d;

    logic [10:0] step_x, step_y;
    logic        step_hdir, step_vdir;

    duck_motion_step u_step (
        .x_in     (xpos_q),
        .y_in     (ypos_q),
        .hdir_in  (hdir_q),
        .vdir_in  (vdir_q),
        .x_speed  (XS),
        .y_speed  (YS),
        .x_max    (X_MAX),
        .y_max    (Y_FLY),
        .x_out    (step_x),
        .y_out    (step_y),
        .hdir_out (step_hdir),
        .vdir_out (step_vdir)
    );

    always_comb begin
        state_d   = state_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        hdir_d    = hdir_q;
        vdir_d    = vdir_q;
        cnt_d     = cnt_q;
        killed_d  = 1'b0;
        escaped_d = 1'b0;

        case (state_q)
            DUCK_IDLE: begin
                if (start) begin
                    xpos_d  = (start_xpos > X_MAX) ? X_MAX : start_xpos;
                    ypos_d  = Y_FLY;
                    hdir_d  = start_dir;
                    vdir_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = DUCK_FLY;
                end
            end
            DUCK_FLY: begin
                // A hit landing on a tick freezes the duck where it is.
                if (hit) begin
                    cnt_d   = '0;
                    state_d = DUCK_HIT;
                end else if (frame_tick) begin
                    xpos_d = step_x;
                    ypos_d = step_y;
                    hdir_d = step_hdir;
                    vdir_d = step_vdir;
                    if (cnt_q == FLY_LAST) begin
                        cnt_d   = '0;
                        state_d = DUCK_ESCAPE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DUCK_HIT: begin
                if (frame_tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = DUCK_FALL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DUCK_FALL: begin
                if (frame_tick) begin
                    if (({1'b0, ypos_q} + FS) >= {1'b0, Y_DEAD}) begin
                        ypos_d   = Y_DEAD;
                        killed_d = 1'b1;
                        state_d  = DUCK_IDLE;
                    end else begin
                        ypos_d = ypos_q + FS[10:0];
                    end
                end
            end
            DUCK_ESCAPE: begin
                if (frame_tick) begin
                    if (ypos_q <= YS) begin
                        ypos_d    = '0;
                        escaped_d = 1'b1;
                        state_d   = DUCK_IDLE;
                    end else begin
                        ypos_d = ypos_q - YS;
                    end
                end
            end
            default: state_d = DUCK_IDLE;
        endcase

        visible_d = (state_d != DUCK_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DUCK_IDLE;
            xpos_q    <= '0;
            ypos_q    <= '0;
            hdir_q    <= 1'b0;
            vdir_q    <= 1'b0;
            cnt_q     <= '0;
            killed_q  <= 1'b0;
            escaped_q <= 1'b0;
            visible_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            hdir_q    <= hdir_d;
            vdir_q    <= vdir_d;
            cnt_q     <= cnt_d;
            killed_q  <= killed_d;
            escaped_q <= escaped_d;
            visible_q <= visible_d;
        end
    end

    assign duck_xpos    = xpos_q;
    assign duck_ypos    = ypos_q;
    assign duck_state   = state_q;
    assign duck_visible = visible_q;
    assign duck_killed  = killed_q;
    assign duck_escaped = escaped_q;

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Directed bench for duck_flight_ctrl: launch, bounce, hit/fall, escape, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_duck_flight_ctrl;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [10:0] start_xpos = '0;
    logic        start_dir = 1'b0;
    logic        hit = 1'b0;
    logic [10:0] duck_xpos;
    logic [10:0] duck_ypos;
    duck_state_t duck_state;
    logic        duck_visible;
    logic        duck_killed;
    logic        duck_escaped;

    int n_checks = 0;
    int n_fail   = 0;

    duck_flight_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .start        (start),
        .start_xpos   (start_xpos),
        .start_dir    (start_dir),
        .hit          (hit),
        .duck_xpos    (duck_xpos),
        .duck_ypos    (duck_ypos),
        .duck_state   (duck_state),
        .duck_visible (duck_visible),
        .duck_killed  (duck_killed),
        .duck_escaped (duck_escaped)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given pulses held high; outputs sampled 1ns after the edge.
    task automatic cyc(input logic t, input logic s, input logic h, input logic r);
        frame_tick = t;
        start      = s;
        hit        = h;
        rst        = r;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
        hit        = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic launch(input int x, input logic dir);
        start_xpos = 11'(x);
        start_dir  = dir;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_pos(input string tag, input int x, input int y);
        check_val({tag, "_x"}, int'(duck_xpos), x);
        check_val({tag, "_y"}, int'(duck_ypos), y);
    endtask

    int prev_y;
    int exp_y;
    int saved_x;
    int pulses;
    int n;

    initial begin
        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("rst_state", int'(duck_state), 0);
        check_pos("rst", 0, 0);
        check_val("rst_vis", int'(duck_visible), 0);
        check_val("rst_kill", int'(duck_killed), 0);
        check_val("rst_esc", int'(duck_escaped), 0);

        // Launch right from 100, one tick
        launch(100, 1'b1);
        check_val("launch_state", int'(duck_state), 1);
        check_pos("launch", 100, 540);
        check_val("launch_vis", int'(duck_visible), 1);
        ticks(1);
        check_pos("fly1", 104, 537);

        // start during FLY is ignored
        launch(500, 1'b0);
        check_pos("start_ign", 104, 537);
        check_val("start_ign_state", int'(duck_state), 1);

        // One tick used so far; escape on the 600th tick
        ticks(598);
        check_val("fly_599", int'(duck_state), 1);
        ticks(1);
        check_val("esc_enter", int'(duck_state), 4);

        // hit during ESCAPE is ignored
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("esc_hit_ign", int'(duck_state), 4);

        saved_x = int'(duck_xpos);
        prev_y  = int'(duck_ypos);
        pulses  = 0;
        n       = 0;
        while (duck_state == DUCK_ESCAPE && n < 400) begin
            exp_y = (prev_y <= 3) ? 0 : prev_y - 3;
            ticks(1);
            check_pos("esc_step", saved_x, exp_y);
            if (duck_escaped) pulses++;
            prev_y = int'(duck_ypos);
            n++;
        end
        check_val("esc_done_state", int'(duck_state), 0);
        check_val("esc_done_y", int'(duck_ypos), 0);
        check_val("esc_done_vis", int'(duck_visible), 0);
        // IDLE: ticks and hit do nothing
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        if (duck_escaped) pulses++;
        check_val("esc_pulses", pulses, 1);
        check_val("idle_hit_state", int'(duck_state), 0);
        check_pos("idle_hold", saved_x, 0);
        ticks(2);
        check_pos("idle_hold2", saved_x, 0);

        // Launch clamp at right edge and bounce
        launch(2000, 1'b1);
        check_pos("clamp", 928, 540);
        ticks(1);
        check_pos("clamp_t1", 928, 537);
        ticks(1);
        check_pos("clamp_t2", 924, 534);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Approach right edge from 920
        launch(920, 1'b1);
        ticks(1);
        check_val("r920_t1", int'(duck_xpos), 924);
        ticks(1);
        check_val("r920_t2", int'(duck_xpos), 928);
        ticks(1);
        check_val("r920_t3", int'(duck_xpos), 924);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Left edge bounce from 3
        launch(3, 1'b0);
        ticks(1);
        check_pos("l3_t1", 0, 537);
        ticks(1);
        check_pos("l3_t2", 4, 534);
        ticks(18);
        check_pos("l3_t20", 76, 480);

        // hit together with tick: freeze, hold 30 ticks, then fall
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check_val("hit_state", int'(duck_state), 2);
        check_pos("hit_frozen", 76, 480);
        ticks(29);
        check_val("hold_29", int'(duck_state), 2);
        check_pos("hold_frozen", 76, 480);
        ticks(1);
        check_val("fall_enter", int'(duck_state), 3);
        ticks(1);
        check_pos("fall1", 76, 486);
        ticks(1);
        check_pos("fall2", 76, 492);
        ticks(1);
        check_pos("fall3", 76, 498);
        check_val("fall3_kill", int'(duck_killed), 0);
        ticks(1);
        check_pos("fall_land", 76, 504);
        check_val("kill_pulse", int'(duck_killed), 1);
        check_val("kill_state", int'(duck_state), 0);
        ticks(1);
        check_val("kill_once", int'(duck_killed), 0);

        // rst during FALL with a tick: no kill pulse
        launch(100, 1'b1);
        ticks(20);
        check_val("r_y480", int'(duck_ypos), 480);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(30);
        check_val("r_fall", int'(duck_state), 3);
        ticks(1);
        check_val("r_fall_y", int'(duck_ypos), 486);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check_val("r_state", int'(duck_state), 0);
        check_pos("r_pos", 0, 0);
        check_val("r_vis", int'(duck_visible), 0);
        check_val("r_kill", int'(duck_killed), 0);
        ticks(1);
        check_val("r_kill2", int'(duck_killed), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
